// File: rtl/bht_update_scheduler_pkg.sv
// Shared definitions for the branch history table update scheduler:
// PC-to-index extraction, FSM encodings and default table geometry.
`define BHT_PC_IDX(pc, w) pc[(w)+1:2]

package bht_update_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } bht_state_e;

    localparam int BHT_IDX_W  = 7;
    localparam int BHT_CTR_W  = 2;
    localparam int BHT_QDEPTH = 4;

    localparam logic [BHT_CTR_W-1:0] BHT_CTR_MAX = {BHT_CTR_W{1'b1}};

endpackage

// File: rtl/bht_commit_fifo.sv
// Small FIFO of committed branches, each entry {taken, index}.
// The occupancy count is one bit wider than the pointers so full and empty differ.
module bht_commit_fifo #(
    parameter int IDX_W  = 7,
    parameter int QDEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [IDX_W:0]   i_push_data,
    input  logic             i_pop,
    output logic [IDX_W:0]   o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(QDEPTH);

    logic [IDX_W:0] r_mem [QDEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW:0]    r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + PW'(1);
            if (i_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == (PW+1)'(QDEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bht_update_scheduler.sv
// Shares the counter table's single read port between fetch lookups and
// commit-time read-modify-write updates, and clears the table after reset.
module bht_update_scheduler
    import bht_update_scheduler_pkg::*;
#(
    parameter int                 IDX_W    = BHT_IDX_W,
    parameter int                 CTR_W    = BHT_CTR_W,
    parameter int                 QDEPTH   = BHT_QDEPTH,
    parameter logic [CTR_W-1:0]   INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [31:0]       if_pc,
    output logic              if_gnt,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              rob_valid,
    input  logic [31:0]       rob_pc,
    input  logic              rob_taken,
    output logic              rob_ready,
    output logic              busy,
    output logic              tbl_re,
    output logic [IDX_W-1:0]  tbl_raddr,
    input  logic [CTR_W-1:0]  tbl_rdata,
    output logic              tbl_we,
    output logic [IDX_W-1:0]  tbl_waddr,
    output logic [CTR_W-1:0]  tbl_wdata,
    output logic [1:0]        dbg_state
);

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    bht_state_e       r_state;
    bht_state_e       w_next_state;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [CTR_W-1:0] r_ctr;
    logic             r_pred_valid;
    logic             r_pred_zero;
    logic             r_pred_fwd;
    logic             r_pred_fwd_bit;

    logic             w_en;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_rob_idx;
    logic [IDX_W:0]   w_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CTR_W-1:0] w_new_ctr;
    logic             w_init_lookup;
    logic             w_unused_pc;

    // Outputs stay quiet both while frozen and while reset is held.
    assign w_en       = rdy & rst;
    assign w_if_idx   = `BHT_PC_IDX(if_pc, IDX_W);
    assign w_rob_idx  = `BHT_PC_IDX(rob_pc, IDX_W);
    assign w_unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0], rob_pc[31:IDX_W+2], rob_pc[1:0]};

    assign w_head_idx   = w_head[IDX_W-1:0];
    assign w_head_taken = w_head[IDX_W];
    assign w_push       = w_en & rob_valid & ~w_full;
    assign w_pop        = w_en & (r_state == ST_WR);

    bht_commit_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_push      (w_push),
        .i_push_data ({rob_taken, w_rob_idx}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_new_ctr = r_ctr;
        if (w_head_taken && (r_ctr != CTR_MAX))
            w_new_ctr = r_ctr + CTR_W'(1);
        else if (!w_head_taken && (r_ctr != '0))
            w_new_ctr = r_ctr - CTR_W'(1);
    end

    always_comb begin
        w_next_state  = r_state;
        if_gnt        = 1'b0;
        tbl_re        = 1'b0;
        tbl_raddr     = w_if_idx;
        tbl_we        = 1'b0;
        tbl_waddr     = w_head_idx;
        tbl_wdata     = w_new_ctr;
        w_init_lookup = 1'b0;
        if (w_en) begin
            case (r_state)
                ST_INIT: begin
                    tbl_we        = 1'b1;
                    tbl_waddr     = r_sweep_idx;
                    tbl_wdata     = INIT_VAL;
                    if_gnt        = if_req;
                    w_init_lookup = if_req;
                    if (r_sweep_idx == IDX_LAST)
                        w_next_state = ST_IDLE;
                end
                ST_IDLE: begin
                    // A full queue steals the port so commits cannot stall forever.
                    if (!w_empty && (w_full || !if_req)) begin
                        tbl_re       = 1'b1;
                        tbl_raddr    = w_head_idx;
                        w_next_state = ST_RD;
                    end else begin
                        if_gnt = if_req;
                        tbl_re = if_req;
                    end
                end
                ST_RD: begin
                    if_gnt       = if_req;
                    tbl_re       = if_req;
                    w_next_state = ST_WR;
                end
                ST_WR: begin
                    if_gnt       = if_req;
                    tbl_re       = if_req;
                    tbl_we       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_INIT;
            r_sweep_idx    <= '0;
            r_ctr          <= '0;
            r_pred_valid   <= 1'b0;
            r_pred_zero    <= 1'b0;
            r_pred_fwd     <= 1'b0;
            r_pred_fwd_bit <= 1'b0;
        end else if (rdy) begin
            r_state <= w_next_state;
            if (r_state == ST_INIT)
                r_sweep_idx <= r_sweep_idx + IDX_W'(1);
            if (r_state == ST_RD)
                r_ctr <= tbl_rdata;
            r_pred_valid   <= if_gnt;
            r_pred_zero    <= w_init_lookup;
            r_pred_fwd     <= if_gnt & tbl_we & (tbl_waddr == w_if_idx);
            r_pred_fwd_bit <= tbl_wdata[CTR_W-1];
        end
    end

    assign pred_valid = r_pred_valid & rdy;
    assign pred_taken = r_pred_zero ? 1'b0 :
                        r_pred_fwd  ? r_pred_fwd_bit : tbl_rdata[CTR_W-1];
    assign busy       = (r_state == ST_INIT);
    assign rob_ready  = ~w_full;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler with a behavioural counter table,
// a write scoreboard and hand-computed expectations.
module tb_bht_update_scheduler;
    import bht_update_scheduler_pkg::*;

    localparam int IDX_W = 7;
    localparam int CTR_W = 2;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              if_req;
    logic [31:0]       if_pc;
    logic              if_gnt;
    logic              pred_valid;
    logic              pred_taken;
    logic              rob_valid;
    logic [31:0]       rob_pc;
    logic              rob_taken;
    logic              rob_ready;
    logic              busy;
    logic              tbl_re;
    logic [IDX_W-1:0]  tbl_raddr;
    logic [CTR_W-1:0]  tbl_rdata;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_waddr;
    logic [CTR_W-1:0]  tbl_wdata;
    logic [1:0]        dbg_state;

    logic [CTR_W-1:0]        tbl_mem [1<<IDX_W];
    logic [IDX_W+CTR_W-1:0]  exp_q [$];
    int n_total = 0;
    int n_bad   = 0;

    bht_update_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_pc      (if_pc),
        .if_gnt     (if_gnt),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .rob_valid  (rob_valid),
        .rob_pc     (rob_pc),
        .rob_taken  (rob_taken),
        .rob_ready  (rob_ready),
        .busy       (busy),
        .tbl_re     (tbl_re),
        .tbl_raddr  (tbl_raddr),
        .tbl_rdata  (tbl_rdata),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // table model: 1-cycle read latency, read returns pre-write contents
    always @(posedge clk) begin
        if (tbl_we)
            tbl_mem[tbl_waddr] <= tbl_wdata;
        if (tbl_re)
            tbl_rdata <= tbl_mem[tbl_raddr];
    end

    always @(posedge clk)
        if (rst && rdy && rob_valid)
            assert (rob_ready) else $error("commit pushed while queue full");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // write scoreboard
    always @(negedge clk) begin
        #2;
        if (rst && tbl_we) begin
            if (exp_q.size() == 0)
                check("unexp_wr", {tbl_waddr, tbl_wdata}, 32'h1ff_0000);
            else
                check("wr", {tbl_waddr, tbl_wdata}, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic run_sweep(input bit with_fetch);
        for (int i = 0; i < (1 << IDX_W); i++)
            exp_q.push_back({IDX_W'(i), CTR_W'(0)});
        @(negedge clk);
        rst = 1'b1; if_req = with_fetch; if_pc = 32'h100;
        #1;
        check("sw_busy0", busy, 1);
        check("sw_state", dbg_state, ST_INIT);
        if (with_fetch) begin
            check("sw_gnt", if_gnt, 1);
            check("sw_re", tbl_re, 0);
        end
        for (int i = 1; i < (1 << IDX_W); i++) begin
            @(negedge clk);
            if (i == 3) if_req = 1'b0;
            #1;
            check("sw_busy", busy, 1);
            if (with_fetch && i <= 2) begin
                check("sw_gnt", if_gnt, 1);
                check("sw_re", tbl_re, 0);
            end
            if (with_fetch && i <= 3) begin
                check("sw_pv", pred_valid, 1);
                check("sw_pt", pred_taken, 0);
            end
        end
        @(negedge clk); #1;
        check("sw_done", busy, 0);
        check("sw_idle", dbg_state, ST_IDLE);
    endtask

    task automatic commit(input logic [31:0] pc, input logic tk);
        @(negedge clk);
        rob_valid = 1'b1; rob_pc = pc; rob_taken = tk; if_req = 1'b0;
        #1;
        check("cm_rdy", rob_ready, 1);
    endtask

    task automatic do_update(input logic [IDX_W-1:0] idx, input logic [CTR_W-1:0] wdata);
        @(negedge clk); rob_valid = 1'b0; if_req = 1'b0; #1;
        check("up_re", tbl_re, 1);
        check("up_raddr", tbl_raddr, idx);
        @(negedge clk); #1;
        check("up_rd", dbg_state, ST_RD);
        check("up_rd_we", tbl_we, 0);
        exp_q.push_back({idx, wdata});
        @(negedge clk); #1;
        check("up_we", tbl_we, 1);
        check("up_waddr", tbl_waddr, idx);
        check("up_wdata", tbl_wdata, wdata);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; if_req = 1'b1; if_pc = 32'h0;
        rob_valid = 1'b0; rob_pc = 32'h0; rob_taken = 1'b0;
        #3;
        check("rst_busy", busy, 1);
        check("rst_we", tbl_we, 0);
        check("rst_re", tbl_re, 0);
        check("rst_gnt", if_gnt, 0);
        check("rst_pv", pred_valid, 0);
        check("rst_rr", rob_ready, 1);
        @(negedge clk);
        if_req = 1'b0;

        run_sweep(1'b0);

        // saturating increments from 1 at idx 64
        tbl_mem[64] = 2'd1;
        commit(32'h100, 1'b1); do_update(7'd64, 2'd2);
        commit(32'h100, 1'b1); do_update(7'd64, 2'd3);
        commit(32'h100, 1'b1); do_update(7'd64, 2'd3);

        // fill the queue under continuous fetch
        if_pc = 32'h200;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if_req = 1'b1; rob_valid = 1'b1;
            rob_pc = 32'h10 + 32'(4 * k); rob_taken = (k != 1);
            #1;
            check("fill_rdy", rob_ready, 1);
            check("fill_gnt", if_gnt, 1);
            if (k > 0) check("fill_pv", pred_valid, 1);
        end
        @(negedge clk); rob_valid = 1'b0; #1;
        check("full_rdy", rob_ready, 0);
        check("full_gnt", if_gnt, 0);
        check("full_re", tbl_re, 1);
        check("full_raddr", tbl_raddr, 4);
        @(negedge clk); #1;
        check("full_rd", dbg_state, ST_RD);
        check("full_rd_gnt", if_gnt, 1);
        check("full_rd_rr", rob_ready, 0);
        exp_q.push_back({7'd4, 2'd1});
        @(negedge clk); #1;
        check("full_we", tbl_we, 1);
        check("full_wdata", tbl_wdata, 1);
        check("full_wr_gnt", if_gnt, 1);
        @(negedge clk); #1;
        check("pop_rdy", rob_ready, 1);
        check("pop_gnt", if_gnt, 1);
        check("pop_re_fetch", tbl_raddr, 0);
        do_update(7'd5, 2'd0);
        do_update(7'd6, 2'd1);
        do_update(7'd7, 2'd1);

        // fetch hitting the index written in the same cycle
        tbl_mem[64] = 2'd1;
        commit(32'h100, 1'b1);
        @(negedge clk); rob_valid = 1'b0; #1;
        check("fw_re", tbl_raddr, 64);
        @(negedge clk); #1;
        exp_q.push_back({7'd64, 2'd2});
        @(negedge clk); if_req = 1'b1; if_pc = 32'h100; #1;
        check("fw_gnt", if_gnt, 1);
        check("fw_we", tbl_we, 1);
        check("fw_wdata", tbl_wdata, 2);
        @(negedge clk); if_req = 1'b0; #1;
        check("fw_pv", pred_valid, 1);
        check("fw_pt", pred_taken, 1);

        // freeze for 5 cycles in WR
        commit(32'h10, 1'b1);
        @(negedge clk); rob_valid = 1'b0; #1;
        check("fz_re", tbl_raddr, 4);
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rdy = 1'b0; if_req = 1'b1; rob_valid = 1'b1; rob_pc = 32'h40; rob_taken = 1'b1;
            #1;
            check("fz_we", tbl_we, 0);
            check("fz_re", tbl_re, 0);
            check("fz_gnt", if_gnt, 0);
            check("fz_state", dbg_state, ST_WR);
        end
        exp_q.push_back({7'd4, 2'd2});
        @(negedge clk); rdy = 1'b1; if_req = 1'b0; rob_valid = 1'b0; #1;
        check("rs_we", tbl_we, 1);
        check("rs_wdata", tbl_wdata, 2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check("rs_quiet", tbl_re, 0);
        end

        // reset during RD with two commits queued
        commit(32'h14, 1'b1);
        @(negedge clk); rob_pc = 32'h18; rob_taken = 1'b0; #1;
        check("rr_raddr", tbl_raddr, 5);
        @(negedge clk); rob_valid = 1'b0; #1;
        check("rr_state", dbg_state, ST_RD);
        #1; rst = 1'b0; if_req = 1'b1; #1;
        check("rr_busy", busy, 1);
        check("rr_we", tbl_we, 0);
        check("rr_re", tbl_re, 0);
        check("rr_gnt", if_gnt, 0);
        check("rr_pv", pred_valid, 0);
        check("rr_rr", rob_ready, 1);
        @(negedge clk);
        run_sweep(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("rr_lost", tbl_re, 0);
        end

        @(negedge clk); #3;
        check("exp_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
- Sequences the branch history counter table (2^IDX_W saturating counters) in the instruction-fetch stage.
- Arbitrates the table's single read port between fetch-time lookups and commit-time read-modify-write updates from the ROB.
- Buffers ROB branch commits in a small queue and performs the post-reset table clear sweep.
- The counter table is an external storage block with 1 read port (1-cycle latency) and 1 write port.

Parameters:
- IDX_W, 7, table index width; index = pc[IDX_W+1:2]
- CTR_W, 2, counter width
- QDEPTH, 4, commit queue entries (power of 2)
- INIT_VAL, 0, counter value written by the clear sweep

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  global enable; low freezes all state
- if_req  in  1  fetch lookup request
- if_pc  in  32  fetch PC
- if_gnt  out  1  lookup accepted this cycle (combinational)
- pred_valid  out  1  lookup result valid, 1 cycle after grant
- pred_taken  out  1  counter MSB of looked-up entry
- rob_valid  in  1  ROB commits a branch
- rob_pc  in  32  committed branch PC
- rob_taken  in  1  real branch outcome
- rob_ready  out  1  queue not full
- busy  out  1  clear sweep in progress
- tbl_re  out  1  table read enable
- tbl_raddr  out  IDX_W  read index
- tbl_rdata  in  CTR_W  read data, valid cycle after tbl_re
- tbl_we  out  1  table write enable
- tbl_waddr  out  IDX_W  write index
- tbl_wdata  out  CTR_W  write data

Behaviour:
- Reset (rst=0, async): FSM=INIT, sweep idx=0, queue empty.
  - Outputs at reset: busy=1, tbl_we=0, tbl_re=0, pred_valid=0, if_gnt=0, rob_ready=1.
- rdy=0: no state, queue, or pointer changes.
  - tbl_re, tbl_we, if_gnt and pred_valid are forced to 0.
- INIT:
  - Each cycle: tbl_we=1, waddr=idx, wdata=INIT_VAL, idx++.
  - After idx 2^IDX_W-1, go to IDLE; the sweep takes exactly 2^IDX_W cycles.
  - Fetch requests in INIT: if_gnt=1 and tbl_re=0; pred_valid follows next cycle with pred_taken=0.
  - Commits are still enqueued during INIT.
- Read-port arbitration (IDLE):
  - Default: fetch has priority.
  - When the queue is full, the update read wins and if_gnt=0 for that cycle.
  - An update read is issued only when if_req=0 or the queue is full.
- Update FSM: IDLE -> RD -> WR -> IDLE.
  - IDLE issues tbl_re for the queue-head index.
  - RD captures tbl_rdata next cycle.
  - WR: tbl_we=1 with the saturated counter: taken and ctr<max gives +1; not-taken and ctr>0 gives -1; otherwise unchanged.
  - The head entry is popped in WR.
  - Minimum 3 cycles per update. No new update read is issued in the WR cycle, so back-to-back same-index updates are always ordered.
- Forwarding: if a granted fetch read in cycle N hits the index written in the same cycle N, pred_taken uses tbl_wdata's MSB, not tbl_rdata.
- Fetch during RD/WR: the read port is free, so if_gnt=if_req.
- Queue:
  - rob_ready = !full.
  - Push when rob_valid && rob_ready.
  - A push while full is dropped; a bench assertion checks that it never occurs.
  - Simultaneous push and pop is allowed.
  - Pointers wrap modulo QDEPTH; a count of width log2(QDEPTH)+1 distinguishes full from empty.
- Reset mid-operation: the queue is discarded, any pending write is abandoned, and the sweep restarts at 0.

Decomposition:
- Shared package/include holds:
  - index-extraction macro pc[IDX_W+1:2]
  - FSM state encodings INIT/IDLE/RD/WR
  - counter max constant
- One natural sub-module: bht_commit_fifo (QDEPTH x (IDX_W+1) entries, holding index and taken bit).

Test Plan:
- Reset, rdy=1, no requests -> busy=1 for 128 cycles; tbl_we writes 0 to idx 0..127 in order; then busy=0.
- Commit rob_pc=0x100, taken=1, table holds 1 -> tbl_re idx 64, then tbl_we idx 64 wdata=2; three updates from 1 saturate at 3.
- Four commits while if_req=1 constantly -> queue full, rob_ready=0, next cycle if_gnt=0 and update tbl_re issued; rob_ready returns high after pop.
- Fetch if_pc=0x100 in the same cycle as WR to idx 64 with wdata=2 -> pred_valid next cycle, pred_taken=1 (forwarded).
- Hold rdy=0 for 5 cycles mid-update -> no tbl_we/tbl_re pulses; FSM resumes in the same state when rdy returns.
- Drive rst low during RD -> outputs go to reset values immediately; sweep restarts at idx 0; queued commits lost.
